pokey_key_matrix: RTL and testbench
===================================

Name: pokey_key_matrix

Overview:
- Emulates the 64-key matrix plus control/shift/break lines that the POKEY keyboard scanner polls.
- Host key events (make/break with a matrix code) are turned into a visible key map. The map is answered combinationally against the scanner's keyboard_scan output, producing keyboard_response[1:0].
- Guarantees that a short host tap stays visible long enough for the scanner's two-pass debounce to latch it.
- Sits directly upstream of pokey_keyboard_scanner. It consumes that block's keyboard_scan and feeds its keyboard_response.

Parameters:
- MIN_PASSES, 2: full scan passes a key must stay visible before a pending release takes effect; legal range 1..3.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ce  in  1  clock enable; same enable as the scanner
- keyboard_scan  in  6  scanner output; inverted scan address, so addr = ~keyboard_scan
- ev_valid  in  1  one-clk pulse; host key event present
- ev_make  in  1  1 = press, 0 = release
- ev_code  in  8  [7:6]=00: matrix key, code in [5:0]; 01: control; 10: shift; 11: break
- all_release  in  1  level/pulse; drop every key and modifier immediately
- keyboard_response  out  2  [0] = matrix line, [1] = modifier line; active-low
- any_key_visible  out  1  OR of the visible matrix map

Behaviour:
- Timing domains:
  - Event capture and all_release act on every clk edge, independent of ce.
  - Pass tracking and release qualification act only on edges with ce=1.
- State:
  - host_down[63:0]: host level per key.
  - vis[63:0]: map presented to the scanner.
  - age[63:0][1:0]: saturating pass count per key.
  - ctrl_r, shift_r, brk_r: modifier levels.
  - prev_addr[5:0].
- Reset: all state cleared; prev_addr = 0. keyboard_response = 2'b11, any_key_visible = 0.
- Matrix make, code k: host_down[k]=1, vis[k]=1, age[k]=0. A make that arrives during a pending release re-arms the key.
- Matrix break, code k: host_down[k]=0. vis[k] is not touched directly.
- Modifier make/break: sets or clears ctrl_r / shift_r / brk_r immediately. No stretching.
- Pass tick: ce=1 and addr==0 and prev_addr==63. prev_addr <= addr on every ce edge.
- On a pass tick, every key with vis=1 increments age, saturating at 3.
- Release qualification (ce edge): for each k with vis[k]=1, host_down[k]=0 and age[k] >= MIN_PASSES:
  - vis[k] <= 0, age[k] <= 0.
  - Uses post-increment age when it coincides with a pass tick.
- Same-clk conflicts:
  - A make for key k in the same clk as its release qualification: make wins; vis stays 1 and age = 0.
  - all_release in the same clk as an event: all_release wins; all state cleared, the event is dropped.
- keyboard_response[0] = ~vis[addr]. Combinational, zero latency from keyboard_scan.
- keyboard_response[1] (combinational):
  - Applies only when addr[3:0]==0. Then addr[5:4]=00 gives ~ctrl_r, 01 gives ~shift_r, 11 gives ~brk_r, 10 gives 1.
  - For any other address it is 1.
- Multiple keys visible at once are allowed. The scanner resolves them by scan order.
- An out-of-order break (no prior make) is harmless: host_down is already 0.
- Reset asserted mid-operation clears everything asynchronously; the response returns to 2'b11 at once.

Decomposition:
- Shared package pokey_kbd_pkg holds:
  - EV_CLASS_KEY=2'b00, EV_CLASS_CTRL=2'b01, EV_CLASS_SHIFT=2'b10, EV_CLASS_BREAK=2'b11.
  - Modifier scan addresses: CTRL=6'h00, SHIFT=6'h10, BREAK=6'h30.
  - The 2-bit age type.
- One natural sub-module, pokey_key_cell: one key's host_down/vis/age logic with make, break, pass_tick and clear inputs. Instantiated 64 times by a generate loop.

Test Plan:
- Reset, with keyboard_scan swept over all 64 values -> keyboard_response == 2'b11 everywhere; any_key_visible == 0.
- Make code 8'h15 and drive addr 0x15 (keyboard_scan = 6'h2A) -> response[0] = 0; every other address gives 1.
- Make 8'h15, break on the next clk, then run a ce-driven scan counter 0..63 repeatedly -> key stays visible through exactly 2 pass ticks, drops on the 2nd tick edge; the scanner raises other_key_irq with keycode 8'h15.
- Key 0x15 released with age=1, then make 0x15 on the same clk as the 2nd pass tick -> vis stays 1, age returns to 0.
- Make shift (8'h80), scan addr 0x10 -> response[1] = 0. Addr 0x20 -> response[1] = 1. Make break (8'hC0), addr 0x30 -> response[1] = 0 and the scanner pulses break_irq.
- Three keys visible, then all_release pulsed in the same clk as a make of 0x3F -> all vis cleared, 0x3F not set, response 2'b11 on the next sample.

Source files
------------

// File: rtl/pokey_kbd_pkg.sv
// Purpose: shared event classes, modifier scan addresses and age type for the POKEY key matrix.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package pokey_kbd_pkg;

    // Host event class, carried in ev_code[7:6]
    localparam logic [1:0] EV_CLASS_KEY   = 2'b00;
    localparam logic [1:0] EV_CLASS_CTRL  = 2'b01;
    localparam logic [1:0] EV_CLASS_SHIFT = 2'b10;
    localparam logic [1:0] EV_CLASS_BREAK = 2'b11;

    // Scan addresses at which the modifier line reports each modifier
    localparam logic [5:0] ADDR_CTRL  = 6'h00;
    localparam logic [5:0] ADDR_SHIFT = 6'h10;
    localparam logic [5:0] ADDR_BREAK = 6'h30;

    // Saturating count of full scan passes a key has been visible
    typedef logic [1:0] age_t;
    localparam age_t AGE_MAX = 2'd3;

endpackage

// File: rtl/pokey_key_cell.sv
// Purpose: one matrix key; tracks host level, scanner-visible level and passes seen while visible.
// Latency: make shows on vis_o one clk after capture; release waits for MIN_PASSES pass ticks.
// Backpressure: none; every event is accepted on the clk it arrives.
// Ports: clk, reset_n, ce, clear_i (drop everything), make_i, brk_i, pass_tick_i -> vis_o
module pokey_key_cell
    import pokey_kbd_pkg::*;
#(
    parameter int MIN_PASSES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic ce,
    input  logic clear_i,
    input  logic make_i,
    input  logic brk_i,
    input  logic pass_tick_i,
    output logic vis_o
);

    logic host_q, host_d;
    logic vis_q,  vis_d;
    age_t age_q,  age_d;
    age_t age_post;
    logic release_ok;

    always_comb begin
        // Age after this edge's pass tick; release qualification looks at this value
        age_post = age_q;
        if (ce && pass_tick_i && vis_q && (age_q != AGE_MAX)) begin
            age_post = age_q + 2'd1;
        end
        release_ok = ce && vis_q && !host_q && (age_post >= age_t'(MIN_PASSES));

        host_d = host_q;
        vis_d  = vis_q;
        age_d  = age_post;
        if (clear_i) begin
            host_d = 1'b0;
            vis_d  = 1'b0;
            age_d  = '0;
        end else if (make_i) begin
            // A make re-arms the key even if a release would qualify this clk
            host_d = 1'b1;
            vis_d  = 1'b1;
            age_d  = '0;
        end else begin
            if (brk_i) begin
                host_d = 1'b0;
            end
            if (release_ok) begin
                vis_d = 1'b0;
                age_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            host_q <= 1'b0;
            vis_q  <= 1'b0;
            age_q  <= '0;
        end else begin
            host_q <= host_d;
            vis_q  <= vis_d;
            age_q  <= age_d;
        end
    end

    assign vis_o = vis_q;

endmodule

// File: rtl/pokey_key_matrix.sv
// Purpose: 64-key matrix plus ctrl/shift/break lines answering the POKEY keyboard scanner.
// Latency: keyboard_response is combinational from keyboard_scan; events land one clk after capture.
// Backpressure: none; host events and all_release are always accepted.
// Ports: clk, reset_n, ce, keyboard_scan[5:0] (inverted address), ev_valid/ev_make/ev_code[7:0],
//        all_release -> keyboard_response[1:0] (active-low matrix/modifier lines), any_key_visible
module pokey_key_matrix
    import pokey_kbd_pkg::*;
#(
    parameter int MIN_PASSES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ce,
    input  logic [5:0] keyboard_scan,
    input  logic       ev_valid,
    input  logic       ev_make,
    input  logic [7:0] ev_code,
    input  logic       all_release,
    output logic [1:0] keyboard_response,
    output logic       any_key_visible
);

    logic [5:0]  addr;
    logic [5:0]  prev_addr_q;
    logic        pass_tick;
    logic        ev_ok;
    logic [1:0]  ev_class;
    logic [63:0] make_vec;
    logic [63:0] brk_vec;
    logic [63:0] vis;
    logic        ctrl_q,  ctrl_d;
    logic        shift_q, shift_d;
    logic        brk_q,   brk_d;

    assign addr      = ~keyboard_scan;
    assign pass_tick = ce && (addr == 6'd0) && (prev_addr_q == 6'd63);
    // all_release swallows any event arriving with it
    assign ev_ok     = ev_valid && !all_release;
    assign ev_class  = ev_code[7:6];

    always_comb begin
        make_vec = '0;
        brk_vec  = '0;
        if (ev_ok && (ev_class == EV_CLASS_KEY)) begin
            if (ev_make) begin
                make_vec[ev_code[5:0]] = 1'b1;
            end else begin
                brk_vec[ev_code[5:0]] = 1'b1;
            end
        end
    end

    always_comb begin
        ctrl_d  = ctrl_q;
        shift_d = shift_q;
        brk_d   = brk_q;
        if (all_release) begin
            ctrl_d  = 1'b0;
            shift_d = 1'b0;
            brk_d   = 1'b0;
        end else if (ev_valid) begin
            case (ev_class)
                EV_CLASS_CTRL:  ctrl_d  = ev_make;
                EV_CLASS_SHIFT: shift_d = ev_make;
                EV_CLASS_BREAK: brk_d   = ev_make;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q      <= 1'b0;
            shift_q     <= 1'b0;
            brk_q       <= 1'b0;
            prev_addr_q <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            shift_q <= shift_d;
            brk_q   <= brk_d;
            if (ce) begin
                prev_addr_q <= addr;
            end
        end
    end

    for (genvar k = 0; k < 64; k++) begin : g_key
        pokey_key_cell #(
            .MIN_PASSES (MIN_PASSES)
        ) u_cell (
            .clk         (clk),
            .reset_n     (reset_n),
            .ce          (ce),
            .clear_i     (all_release),
            .make_i      (make_vec[k]),
            .brk_i       (brk_vec[k]),
            .pass_tick_i (pass_tick),
            .vis_o       (vis[k])
        );
    end

    always_comb begin
        keyboard_response    = 2'b11;
        keyboard_response[0] = ~vis[addr];
        // Modifiers only answer on column 0 of each 16-address row
        if (addr[3:0] == 4'd0) begin
            case (addr)
                ADDR_CTRL:  keyboard_response[1] = ~ctrl_q;
                ADDR_SHIFT: keyboard_response[1] = ~shift_q;
                ADDR_BREAK: keyboard_response[1] = ~brk_q;
                default:    keyboard_response[1] = 1'b1;
            endcase
        end
    end

    assign any_key_visible = |vis;

endmodule

// File: tb/tb_pokey_key_matrix.sv
// Purpose: self-checking bench for pokey_key_matrix; expected {any_key_visible, keyboard_response}
//          tuples are queued as stimulus is applied and compared when the DUT is sampled.
// Latency/backpressure: n/a (testbench).
module tb_pokey_key_matrix;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       ce;
    logic [5:0] keyboard_scan;
    logic       ev_valid;
    logic       ev_make;
    logic [7:0] ev_code;
    logic       all_release;
    logic [1:0] keyboard_response;
    logic       any_key_visible;

    always #5 clk = ~clk;

    pokey_key_matrix #(.MIN_PASSES(2)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .ce                (ce),
        .keyboard_scan     (keyboard_scan),
        .ev_valid          (ev_valid),
        .ev_make           (ev_make),
        .ev_code           (ev_code),
        .all_release       (all_release),
        .keyboard_response (keyboard_response),
        .any_key_visible   (any_key_visible)
    );

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        string      tag;
        logic [2:0] exp;
    } sb_t;
    sb_t sb_q[$];

    task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got {any,resp}=%b expected %b", tag, got, exp);
    endtask

    task automatic sb_push(input string tag, input logic [2:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic sb_drain();
        while (sb_q.size() > 0) begin
            sb_t e;
            e = sb_q.pop_front();
            check(e.tag, {any_key_visible, keyboard_response}, e.exp);
        end
    endtask

    // Apply an address, queue the expectation and compare on the next falling edge
    task automatic probe(input string tag, input logic [5:0] a, input logic [2:0] exp);
        keyboard_scan = ~a;
        sb_push(tag, exp);
        @(negedge clk);
        sb_drain();
    endtask

    task automatic send(input logic [7:0] code, input logic mk);
        @(posedge clk); #1;
        ev_valid = 1'b1;
        ev_make  = mk;
        ev_code  = code;
        @(posedge clk); #1;
        ev_valid = 1'b0;
    endtask

    task automatic do_reset();
        ce          = 1'b0;
        ev_valid    = 1'b0;
        all_release = 1'b0;
        reset_n     = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        keyboard_scan = 6'h3F;
        ev_make       = 1'b0;
        ev_code       = 8'h00;
        do_reset();

        // Reset state across every scan address
        for (int a = 0; a < 64; a++) probe("rst_sweep", 6'(a), 3'b011);

        // Single key make: only its own address answers
        send(8'h15, 1'b1);
        for (int a = 0; a < 64; a++)
            probe("key15_sweep", 6'(a), {1'b1, 1'b1, (a != 'h15)});

        // Tap: make then break, key must last exactly two pass ticks
        do_reset();
        send(8'h15, 1'b1);
        send(8'h15, 1'b0);
        for (int i = 0; i < 200; i++) begin
            logic [5:0] a;
            logic       v;
            a = 6'(i % 64);
            v = (i < 128);
            keyboard_scan = ~a;
            ce = 1'b1;
            if (a == 6'h15) sb_push("tap_pre", {v, 1'b1, ~v});
            @(negedge clk);
            sb_drain();
            @(posedge clk); #1;
            if (a == 6'd0 || a == 6'd63) begin
                sb_push("tap_edge", {v, 2'b11});
                sb_drain();
            end
        end
        ce = 1'b0;

        // Re-make on the clk of the 2nd pass tick resets the age
        do_reset();
        send(8'h15, 1'b1);
        send(8'h15, 1'b0);
        for (int i = 0; i < 300; i++) begin
            logic [5:0] a;
            logic       v;
            a = 6'(i % 64);
            v = (i < 256);
            keyboard_scan = ~a;
            ce = 1'b1;
            if (i == 128 || i == 129) begin
                ev_valid = 1'b1;
                ev_make  = (i == 128);
                ev_code  = 8'h15;
            end
            if (a == 6'h15) sb_push("remake_pre", {v, 1'b1, ~v});
            @(negedge clk);
            sb_drain();
            @(posedge clk); #1;
            ev_valid = 1'b0;
            if (i == 64 || i == 128 || i == 129 || i == 192 || i == 255 || i == 256) begin
                sb_push("remake_edge", {v, 1'b1, (a != 6'h15)});
                sb_drain();
            end
        end
        ce = 1'b0;

        // Modifier lines
        do_reset();
        send(8'h80, 1'b1);
        probe("shift_10", 6'h10, 3'b001);
        probe("shift_20", 6'h20, 3'b011);
        probe("ctrl_off", 6'h00, 3'b011);
        send(8'hC0, 1'b1);
        probe("brk_30", 6'h30, 3'b001);
        send(8'h40, 1'b1);
        probe("ctrl_00", 6'h00, 3'b001);
        send(8'h80, 1'b0);
        probe("shift_rel", 6'h10, 3'b011);
        probe("brk_hold", 6'h30, 3'b001);

        // all_release beats a simultaneous make
        do_reset();
        send(8'h01, 1'b1);
        send(8'h22, 1'b1);
        send(8'h30, 1'b1);
        send(8'h80, 1'b1);
        probe("pre_rel_22", 6'h22, 3'b110);
        @(posedge clk); #1;
        ev_valid    = 1'b1;
        ev_make     = 1'b1;
        ev_code     = 8'h3F;
        all_release = 1'b1;
        @(posedge clk); #1;
        ev_valid    = 1'b0;
        all_release = 1'b0;
        probe("rel_3f", 6'h3F, 3'b011);
        probe("rel_22", 6'h22, 3'b011);
        probe("rel_10", 6'h10, 3'b011);
        probe("rel_30", 6'h30, 3'b011);

        // Asynchronous reset mid-operation
        send(8'h05, 1'b1);
        probe("pre_arst", 6'h05, 3'b110);
        #1;
        reset_n = 1'b0;
        sb_push("arst", 3'b011);
        #1;
        sb_drain();
        reset_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
